// File: rtl/adder_tree_acc_if.sv
// Beat-in / result-out bundle for adder_tree_acc, with one modport per side.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// a source holds valid and its payload stable until that edge, and ready may not depend on valid.
interface adder_tree_acc_if #(
  parameter int INPUT_NUM = 8,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = IN_WIDTH + $clog2(INPUT_NUM) + 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [INPUT_NUM*IN_WIDTH-1:0] din;
  logic [INPUT_NUM-1:0]          in_mask;
  logic                          acc_en;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_WIDTH-1:0]          dout;
  logic [15:0]                   out_beats;

  modport master (
    output in_valid, din, in_mask, acc_en, in_last, out_ready,
    input  in_ready, out_valid, dout, out_beats
  );

  modport slave (
    input  in_valid, din, in_mask, acc_en, in_last, out_ready,
    output in_ready, out_valid, dout, out_beats
  );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined masked adder tree with optional multi-beat frame accumulation.
// One global advance enable stalls every stage together when the result is not taken.
module adder_tree_acc #(
  parameter int INPUT_NUM = 8,
  parameter int IN_WIDTH  = 16,
  parameter bit SIGNED    = 1'b1,
  parameter int ACC_WIDTH = IN_WIDTH + $clog2(INPUT_NUM) + 8
) (
  input  logic              clk,
  input  logic              rst,
  adder_tree_acc_if.slave   bus,
  output logic              state_dbg
);

  localparam int STAGE_NUM = $clog2(INPUT_NUM);
  localparam int PAD       = 1 << STAGE_NUM;
  localparam int TREE_W    = IN_WIDTH + STAGE_NUM;
  localparam int NODE_NUM  = 2 * PAD - 1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Tree nodes are stored level by level: level s starts at 2*PAD - 2*(PAD>>s).
  function automatic int stage_off(input int s);
    return 2 * PAD - 2 * (PAD >> s);
  endfunction

  function automatic logic [TREE_W-1:0] extend_lane(input logic [IN_WIDTH-1:0] x);
    if (SIGNED) return TREE_W'($signed(x));
    else        return TREE_W'(x);
  endfunction

  logic [TREE_W-1:0]     node [NODE_NUM];
  logic [STAGE_NUM:0]    st_valid;
  logic [STAGE_NUM:0]    st_acc;
  logic [STAGE_NUM:0]    st_last;
  logic [PAD-1:0]        mask_pad;
  logic [PAD*IN_WIDTH-1:0] din_pad;
  logic                  adv;
  logic                  tree_valid;
  logic                  tree_acc;
  logic                  tree_last;
  logic [ACC_WIDTH-1:0]  tree_sum;
  logic [ACC_WIDTH-1:0]  acc_plus;
  logic [15:0]           cnt_inc;
  state_t                state;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [15:0]           cnt_q;
  logic [ACC_WIDTH-1:0]  dout_q;
  logic [15:0]           beats_q;
  logic                  out_valid_q;

  assign adv           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_beats = beats_q;
  assign state_dbg     = (state == ACCUM);

  // Pad lanes carry a zero mask so they always contribute 0.
  assign mask_pad = PAD'(bus.in_mask);
  assign din_pad  = (PAD * IN_WIDTH)'(bus.din);

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < PAD; k++) begin
        node[k] <= mask_pad[k] ? extend_lane(din_pad[k*IN_WIDTH +: IN_WIDTH]) : '0;
      end
      for (int s = 1; s <= STAGE_NUM; s++) begin
        for (int i = 0; i < (PAD >> s); i++) begin
          node[stage_off(s) + i] <= node[stage_off(s-1) + 2*i] + node[stage_off(s-1) + 2*i + 1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= '0;
      st_acc   <= '0;
      st_last  <= '0;
    end else if (adv) begin
      st_valid[0] <= bus.in_valid;
      st_acc[0]   <= bus.acc_en;
      st_last[0]  <= bus.in_last;
      for (int s = 1; s <= STAGE_NUM; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_acc[s]   <= st_acc[s-1];
        st_last[s]  <= st_last[s-1];
      end
    end
  end

  assign tree_valid = st_valid[STAGE_NUM];
  assign tree_acc   = st_acc[STAGE_NUM];
  assign tree_last  = st_last[STAGE_NUM];

  always_comb begin
    tree_sum = '0;
    if (SIGNED) tree_sum = ACC_WIDTH'($signed(node[NODE_NUM-1]));
    else        tree_sum = ACC_WIDTH'(node[NODE_NUM-1]);
    acc_plus = acc_q + tree_sum;
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  // With adv high the previous result is either absent or being taken this edge,
  // so out_valid simply becomes "a result loads now".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= 1'b0;
      if (tree_valid) begin
        case (state)
          IDLE: begin
            if (tree_acc && !tree_last) begin
              acc_q <= tree_sum;
              cnt_q <= 16'd1;
              state <= ACCUM;
            end else begin
              dout_q      <= tree_sum;
              beats_q     <= 16'd1;
              out_valid_q <= 1'b1;
            end
          end
          ACCUM: begin
            if (!tree_last) begin
              acc_q <= acc_plus;
              cnt_q <= cnt_inc;
            end else begin
              dout_q      <= acc_plus;
              beats_q     <= cnt_inc;
              out_valid_q <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: default build plus an unsigned build and a 5-lane build.
// Results of the default build are predicted by a frame model and matched through exp_q.
module tb_adder_tree_acc;

  localparam int N  = 8;
  localparam int IW = 16;
  localparam int AW = IW + $clog2(N) + 8;
  localparam int EW = AW + 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_tree_acc_if #(.INPUT_NUM(N), .IN_WIDTH(IW), .ACC_WIDTH(AW)) bus ();
  adder_tree_acc_if #(.INPUT_NUM(8), .IN_WIDTH(16), .ACC_WIDTH(AW)) bus_u ();
  adder_tree_acc_if #(.INPUT_NUM(5), .IN_WIDTH(16), .ACC_WIDTH(AW)) bus_5 ();
  logic state_dbg, state_dbg_u, state_dbg_5;

  adder_tree_acc #(.INPUT_NUM(N), .IN_WIDTH(IW), .SIGNED(1'b1), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));
  adder_tree_acc #(.INPUT_NUM(8), .IN_WIDTH(16), .SIGNED(1'b0), .ACC_WIDTH(AW)) dut_u (
    .clk(clk), .rst(rst), .bus(bus_u), .state_dbg(state_dbg_u));
  adder_tree_acc #(.INPUT_NUM(5), .IN_WIDTH(16), .SIGNED(1'b1), .ACC_WIDTH(AW)) dut_5 (
    .clk(clk), .rst(rst), .bus(bus_5), .state_dbg(state_dbg_5));

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  logic [EW-1:0] exp_q[$];

  bit     in_frame = 1'b0;
  longint facc     = 0;
  int     fcnt     = 0;
  bit     drv_done = 1'b0;

  function automatic logic [N*IW-1:0] all_lanes(input logic [IW-1:0] v);
    logic [N*IW-1:0] r;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = v;
    return r;
  endfunction

  function automatic logic [N*IW-1:0] ramp_lanes();
    logic [N*IW-1:0] r;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(k + 1);
    return r;
  endfunction

  function automatic longint lane_sum(input logic [N*IW-1:0] d, input logic [N-1:0] m);
    longint s;
    logic signed [IW-1:0] l;
    s = 0;
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        l = d[k*IW +: IW];
        s = s + longint'(l);
      end
    end
    return s;
  endfunction

  task automatic model_accept(input logic [N*IW-1:0] d, input logic [N-1:0] m,
                              input logic ae, input logic last);
    longint s;
    int     b;
    s = lane_sum(d, m);
    if (!in_frame) begin
      if (!ae || last) exp_q.push_back({AW'(s), 16'd1});
      else begin
        in_frame = 1'b1;
        facc     = s;
        fcnt     = 1;
      end
    end else if (!last) begin
      facc = facc + s;
      if (fcnt < 65535) fcnt++;
    end else begin
      b = (fcnt + 1 > 65535) ? 65535 : fcnt + 1;
      exp_q.push_back({AW'(facc + s), 16'(b)});
      in_frame = 1'b0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that takes the beat.
  task automatic send_beat(input logic [N*IW-1:0] d, input logic [N-1:0] m,
                           input logic ae, input logic last);
    int n;
    bus.din      = d;
    bus.in_mask  = m;
    bus.acc_en   = ae;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
    end else begin
      model_accept(d, m, ae, last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain pending=%0d required 0", exp_q.size());
    else n_pass++;
  endtask

  // Scoreboard: a result transfers on the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_out++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output dout=%0d beats=%0d required none",
                 $signed(bus.dout), bus.out_beats);
      end else begin
        e = exp_q.pop_front();
        if ({bus.dout, bus.out_beats} !== e)
          $display("FAIL result dout=%0d beats=%0d required dout=%0d beats=%0d",
                   $signed(bus.dout), bus.out_beats, $signed(e[EW-1:16]), e[15:0]);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b required 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.dout !== '0) $display("FAIL rst_dout got=%0d required 0", bus.dout);
    else n_pass++;
    n_checks++;
    if (bus.out_beats !== 16'd0) $display("FAIL rst_beats got=%0d required 0", bus.out_beats);
    else n_pass++;
    n_checks++;
    if (state_dbg !== 1'b0) $display("FAIL rst_state got=%b required 0", state_dbg);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b required 1", bus.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int cyc;
    bus.out_ready = 1'b1;
    bus.din       = ramp_lanes();
    bus.in_mask   = 8'hFF;
    bus.acc_en    = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL lat_in_ready got=%b required 1", bus.in_ready);
    else n_pass++;
    model_accept(ramp_lanes(), 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 5) $display("FAIL latency got=%0d required 5", cyc);
    else n_pass++;
    n_checks++;
    if (bus.dout !== AW'(36)) $display("FAIL lat_dout got=%0d required 36", bus.dout);
    else n_pass++;
    drain();
  endtask

  task automatic test_signed();
    int n;
    send_beat(all_lanes(16'h8000), 8'hFF, 1'b0, 1'b0);
    drain();
    bus_u.din      = all_lanes(16'h8000);
    bus_u.in_mask  = 8'hFF;
    bus_u.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_u.in_valid = 1'b0;
    n = 0;
    while (bus_u.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (bus_u.dout !== AW'(262144)) $display("FAIL unsigned_dout got=%0d required 262144", bus_u.dout);
    else n_pass++;
    n_checks++;
    if (bus_u.out_beats !== 16'd1) $display("FAIL unsigned_beats got=%0d required 1", bus_u.out_beats);
    else n_pass++;
  endtask

  task automatic test_mask();
    int n;
    send_beat(ramp_lanes(), 8'h0F, 1'b0, 1'b0);
    drain();
    bus_5.din      = {5{16'd3}};
    bus_5.in_mask  = 5'h1F;
    bus_5.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_5.in_valid = 1'b0;
    n = 0;
    while (bus_5.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (bus_5.dout !== AW'(15)) $display("FAIL five_lane_dout got=%0d required 15", bus_5.dout);
    else n_pass++;
  endtask

  task automatic test_frame();
    int n0;
    n0 = n_out;
    for (int i = 0; i < 4; i++) send_beat(all_lanes(16'd1), 8'hFF, (i != 2), (i == 3));
    idle(8);
    drain();
    n_checks++;
    if (n_out - n0 != 1) $display("FAIL frame_out_count got=%0d required 1", n_out - n0);
    else n_pass++;
    send_beat(all_lanes(16'd2), 8'hFF, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_beat({$urandom(), $urandom(), $urandom(), $urandom()}, 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        if (in_frame) send_beat(all_lanes(16'd5), 8'hFF, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while ((n < 10 || !drv_done || exp_q.size() != 0) && n < 3000) begin
          @(negedge clk);
          n_checks++;
          if (bus.in_ready !== (!bus.out_valid || bus.out_ready))
            $display("FAIL in_ready_adv got=%b required %b", bus.in_ready,
                     (!bus.out_valid || bus.out_ready));
          else n_pass++;
          @(posedge clk);
          #1;
          n++;
          bus.out_ready = (n < 10) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_pending got=%0d required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bus.out_ready = 1'b1;
    send_beat(all_lanes(16'd1), 8'hFF, 1'b1, 1'b0);
    send_beat(all_lanes(16'd1), 8'hFF, 1'b1, 1'b0);
    idle(6);
    n_checks++;
    if (state_dbg !== 1'b1) $display("FAIL midframe_state got=%b required 1", state_dbg);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL async_out_valid got=%b required 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (state_dbg !== 1'b0) $display("FAIL async_state got=%b required 0", state_dbg);
    else n_pass++;
    n_checks++;
    if (bus.dout !== '0 || bus.out_beats !== 16'd0)
      $display("FAIL async_dout got=%0d/%0d required 0/0", bus.dout, bus.out_beats);
    else n_pass++;
    in_frame = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_beat(all_lanes(16'd1), 8'hFF, 1'b1, (i == 2));
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;   bus.din = '0;   bus.in_mask = '0;
    bus.acc_en = 1'b0;     bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus_u.in_valid = 1'b0; bus_u.din = '0; bus_u.in_mask = '0;
    bus_u.acc_en = 1'b0;   bus_u.in_last = 1'b0; bus_u.out_ready = 1'b1;
    bus_5.in_valid = 1'b0; bus_5.din = '0; bus_5.in_mask = '0;
    bus_5.acc_en = 1'b0;   bus_5.in_last = 1'b0; bus_5.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_signed();
    test_mask();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
